subtraction_fp_seq: RTL
=======================

// Module: subtraction_fp_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision subtractor: o = a - b, truncating (no rounding).
//  Companion to the combinational FP32 adder; used in the Q-learning datapath for TD-error
//  (target - Q). Valid/ready on both sides; iterative normaliser trades latency for area.
// PARAMETERS
//  NORM_STEP  1   max left-shift positions per NORM cycle; legal 1,2,4
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  a          in   32  minuend, FP32
//  b          in   32  subtrahend, FP32
//  in_valid   in   1   operands valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  o          out  32  result, FP32
//  out_valid  out  1   o valid; held until out_ready
//  out_ready  in   1   consumer accepts o
// BEHAVIOUR
//  Reset: state=IDLE, o=0, out_valid=0, in_ready=1. Reset wins over any handshake, incl. mid-NORM.
//  FSM: IDLE -> ALIGN -> ADDSUB -> NORM -> DONE -> IDLE.
//   IDLE:  in_valid&in_ready registers a,b; bS inverted internally (a + (-b)).
//   ALIGN: 24-bit mantissas {1,frac}; exponent field 0 => operand is zero (mantissa 0).
//          smaller-exponent mantissa >> diff; diff>=24 => it becomes 0; tE = larger exponent.
//   ADDSUB: same effective sign: 25-bit sum; carry => >>1, tE+1; tS = aS.
//          different sign: larger mag minus smaller; equal mags => result +0, tS=0.
//          result 0 => skip NORM, go DONE with o=0x00000000.
//   NORM:  while tM[23]==0: shift left min(NORM_STEP, lead-zero count), tE -= shift.
//          tE would reach <=0 => flush to +0 (0x00000000), go DONE.
//          tM[23]==1 on entry => 0 NORM cycles.
//   DONE:  o={tS,tE,tM[22:0]}, out_valid=1; out_ready=1 -> IDLE (in_ready=1 next cycle).
//  Overflow: carry with tE=254 -> o={tS,8'hFF,23'd0} (infinity). NaN/Inf inputs not supported.
//  Latency: out_valid asserts 3+ceil(k/NORM_STEP) cycles after accept, k = lead zeros.
//  Throughput: one op in flight; a,b ignored while in_ready=0. o stable while out_valid=1.
// CONFIGURATION
//  SUB_FP_ADD_MODE_EN defined: extra input port `op` (1 bit) sampled with a,b;
//   op=0 -> a-b, op=1 -> a+b (b sign not inverted). Not defined: no `op` port, always a-b.
// TESTING
//  3.0-1.0: a=0x40400000 b=0x3F800000 -> o=0x40000000, out_valid 3 cycles after accept.
//  1.0-1.0: a=b=0x3F800000 -> o=0x00000000, 3-cycle latency, no NORM cycles.
//  1.0-(-1.0): a=0x3F800000 b=0xBF800000 -> carry path, o=0x40000000.
//  1.0-0x3F7FFFFF -> o=0x34000000; latency 26 (NORM_STEP=1), 9 (NORM_STEP=4).
//  Backpressure: out_ready=0 for 10 cycles -> o, out_valid held, in_ready=0; new a,b ignored.
//  rst pulsed during NORM of case 4 -> next cycle IDLE, o=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/subtraction_fp_seq.sv
// FP32 a-b (truncating), valid/ready both sides; latency 3+ceil(k/NORM_STEP) cycles, k = lead zeros after ADDSUB.
// One op in flight, inputs ignored until result is taken; SUB_FP_ADD_MODE_EN adds an `op` port selecting a+b.
module subtraction_fp_seq #(
    parameter int NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
`ifdef SUB_FP_ADD_MODE_EN
    input  logic        op,
`endif
    output logic        in_ready,
    output logic [31:0] o,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADDSUB,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [4:0] STEP = 5'(NORM_STEP);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] o_q, o_d;
    logic [23:0] ma_q, ma_d;
    logic [23:0] mb_q, mb_d;
    logic [23:0] tm_q, tm_d;
    logic [8:0]  te_q, te_d;
    logic        ts_q, ts_d;

    logic        addsub_done;
    logic        norm_done;
    logic        b_sign_in;
    logic [7:0]  ea, eb, ediff;
    logic [23:0] ma_full, mb_full;
    logic [24:0] sum;
    logic [23:0] mdiff;
    logic [23:0] tm_sh;
    logic [4:0]  lz, sh;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!hit && !v[i]) begin
                n = n + 5'd1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    // b is stored with its effective sign so the datapath only ever adds.
`ifdef SUB_FP_ADD_MODE_EN
    assign b_sign_in = op ? b[31] : ~b[31];
`else
    assign b_sign_in = ~b[31];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            o_q  <= '0;
            ma_q <= '0;
            mb_q <= '0;
            tm_q <= '0;
            te_q <= '0;
            ts_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            o_q  <= o_d;
            ma_q <= ma_d;
            mb_q <= mb_d;
            tm_q <= tm_d;
            te_q <= te_d;
            ts_q <= ts_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADDSUB;
            S_ADDSUB: state_d = addsub_done ? S_DONE : S_NORM;
            S_NORM:   if (norm_done) state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        o_d         = o_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        tm_d        = tm_q;
        te_d        = te_q;
        ts_d        = ts_q;
        addsub_done = 1'b0;
        norm_done   = 1'b0;

        ea      = a_q[30:23];
        eb      = b_q[30:23];
        ma_full = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
        mb_full = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
        ediff   = (ea >= eb) ? (ea - eb) : (eb - ea);
        sum     = {1'b0, ma_q} + {1'b0, mb_q};
        mdiff   = (ma_q >= mb_q) ? (ma_q - mb_q) : (mb_q - ma_q);
        lz      = lzc24(tm_q);
        sh      = (lz < STEP) ? lz : STEP;
        tm_sh   = tm_q << sh;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = {b_sign_in, b[30:0]};
                end
            end
            S_ALIGN: begin
                if (ea >= eb) begin
                    te_d = {1'b0, ea};
                    ma_d = ma_full;
                    mb_d = (ediff >= 8'd24) ? 24'd0 : (mb_full >> ediff);
                end else begin
                    te_d = {1'b0, eb};
                    mb_d = mb_full;
                    ma_d = (ediff >= 8'd24) ? 24'd0 : (ma_full >> ediff);
                end
            end
            S_ADDSUB: begin
                if (a_q[31] == b_q[31]) begin
                    if (sum[24] && te_q == 9'd254) begin
                        ts_d        = a_q[31];
                        te_d        = 9'd255;
                        tm_d        = 24'd0;
                        addsub_done = 1'b1;
                    end else if (sum[24]) begin
                        ts_d        = a_q[31];
                        te_d        = te_q + 9'd1;
                        tm_d        = sum[24:1];
                        addsub_done = 1'b1;
                    end else if (sum[23:0] == 24'd0) begin
                        ts_d        = 1'b0;
                        te_d        = 9'd0;
                        tm_d        = 24'd0;
                        addsub_done = 1'b1;
                    end else begin
                        ts_d        = a_q[31];
                        tm_d        = sum[23:0];
                        addsub_done = sum[23];
                    end
                end else if (mdiff == 24'd0) begin
                    ts_d        = 1'b0;
                    te_d        = 9'd0;
                    tm_d        = 24'd0;
                    addsub_done = 1'b1;
                end else begin
                    ts_d        = (ma_q >= mb_q) ? a_q[31] : b_q[31];
                    tm_d        = mdiff;
                    addsub_done = mdiff[23];
                end
                if (addsub_done) begin
                    o_d = {ts_d, te_d[7:0], tm_d[22:0]};
                end
            end
            S_NORM: begin
                // Exponent would hit zero or below: flush to +0 rather than emit a denormal.
                if (te_q <= {4'd0, sh}) begin
                    ts_d      = 1'b0;
                    te_d      = 9'd0;
                    tm_d      = 24'd0;
                    norm_done = 1'b1;
                end else begin
                    tm_d      = tm_sh;
                    te_d      = te_q - {4'd0, sh};
                    norm_done = tm_sh[23];
                end
                if (norm_done) begin
                    o_d = {ts_d, te_d[7:0], tm_d[22:0]};
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        o         = o_q;
    end

endmodule
